// File: rtl/systolic_pkg.sv
// Shared types and constants for the 8x8 systolic job controller.
package systolic_pkg;
  localparam int MAT_DIM        = 8;
  localparam int MAT_WORDS      = MAT_DIM * MAT_DIM;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ARM   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_STORE = 3'd5,
    ST_FIN   = 3'd6
  } ctrl_state_t;

  typedef logic [0:MAT_DIM-1][0:MAT_DIM-1][DEF_DATA_WIDTH-1:0] mat_data_t;
  typedef logic [0:MAT_DIM-1][0:MAT_DIM-1][DEF_ACC_WIDTH-1:0]  mat_acc_t;
endpackage

// File: rtl/systolic_job_watchdog.sv
// WAIT-state watchdog: counts while enabled, pulses expire on its last allowed cycle.
module systolic_job_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CW'(1);
  end

  assign expire = en && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/systolic_job_ctrl.sv
// Job sequencer for the 8x8 systolic array: load A/B from scratch memory,
// run the array, write C back, report completion or watchdog timeout.
module systolic_job_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_a_base,
  input  logic [ADDR_WIDTH-1:0] cmd_b_base,
  input  logic [ADDR_WIDTH-1:0] cmd_c_base,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ACC_WIDTH-1:0]  wr_data,
  output logic                  arr_start,
  output logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_WIDTH-1:0] arr_A,
  output logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_WIDTH-1:0] arr_B,
  input  logic [0:MAT_DIM-1][0:MAT_DIM-1][ACC_WIDTH-1:0]  arr_C,
  input  logic                  arr_done,
  output logic                  busy,
  output logic                  job_done,
  output logic                  job_err
);
  ctrl_state_t           state;
  logic [6:0]            idx;
  logic [ADDR_WIDTH-1:0] a_base, b_base, c_base;
  logic                  pend_vld;
  logic [6:0]            pend_idx;
  logic                  wd_expire;
  logic [0:MAT_DIM-1][0:MAT_DIM-1][ACC_WIDTH-1:0] c_cap;

  systolic_job_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_WAIT),
    .en    (state == ST_WAIT),
    .expire(wd_expire)
  );

  // Outputs decode straight from state so an async reset clears them at once.
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rd_en     = (state == ST_LOAD);
  assign wr_en     = (state == ST_STORE);
  assign arr_start = (state == ST_ARM) && !arr_done;
  assign job_done  = (state == ST_FIN);
  assign rd_addr   = rd_en ? ((idx[6] ? b_base : a_base) + ADDR_WIDTH'(idx[5:0])) : '0;
  assign wr_addr   = wr_en ? (c_base + ADDR_WIDTH'(idx[5:0])) : '0;
  assign wr_data   = wr_en ? c_cap[idx[5:3]][idx[2:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      a_base   <= '0;
      b_base   <= '0;
      c_base   <= '0;
      pend_vld <= 1'b0;
      pend_idx <= '0;
      job_err  <= 1'b0;
    end else begin
      pend_vld <= rd_en;
      pend_idx <= idx;
      case (state)
        ST_IDLE: if (cmd_valid) begin
          a_base  <= cmd_a_base;
          b_base  <= cmd_b_base;
          c_base  <= cmd_c_base;
          job_err <= 1'b0;
          idx     <= '0;
          state   <= ST_LOAD;
        end
        ST_LOAD: begin
          idx <= idx + 7'd1;
          if (idx == 7'd127) state <= ST_DRAIN;
        end
        ST_DRAIN: state <= ST_ARM;
        // A done still high from the previous job must not start this one.
        ST_ARM:   if (!arr_done) state <= ST_WAIT;
        ST_WAIT: begin
          if (arr_done) begin
            idx   <= '0;
            state <= ST_STORE;
          end else if (wd_expire) begin
            job_err <= 1'b1;
            state   <= ST_FIN;
          end
        end
        ST_STORE: begin
          idx <= idx + 7'd1;
          if (idx == 7'd63) state <= ST_FIN;
        end
        ST_FIN:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Read data lands one cycle after its strobe; pend_* carries the element index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_A <= '0;
      arr_B <= '0;
    end else if (pend_vld) begin
      if (!pend_idx[6]) arr_A[pend_idx[5:3]][pend_idx[2:0]] <= rd_data;
      else              arr_B[pend_idx[5:3]][pend_idx[2:0]] <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              c_cap <= '0;
    else if ((state == ST_WAIT) && arr_done) c_cap <= arr_C;
  end
endmodule

// File: tb/tb_systolic_job_ctrl.sv
// Randomized bench for systolic_job_ctrl with scratch-memory, array stub and reference model.
module tb_systolic_job_ctrl;
  import systolic_pkg::*;

  localparam int AW = 10;
  localparam int TO = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_a_base, cmd_b_base, cmd_c_base;
  logic rd_en, wr_en, arr_start, busy, job_done, job_err;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [15:0] rd_data;
  logic [31:0] wr_data;
  mat_data_t arr_A, arr_B;
  mat_acc_t  arr_C = '0;
  logic      arr_done = 1'b0;

  always #5 clk = ~clk;

  systolic_job_ctrl #(.DATA_WIDTH(16), .ACC_WIDTH(32), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base), .cmd_c_base(cmd_c_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .arr_start(arr_start), .arr_A(arr_A), .arr_B(arr_B), .arr_C(arr_C), .arr_done(arr_done),
    .busy(busy), .job_done(job_done), .job_err(job_err)
  );

  // Scratch memory holds signed element values as plain ints.
  int mem_v [1024];
  always @(posedge clk) if (rd_en) rd_data <= 16'(mem_v[rd_addr]);

  int tests = 0, fails = 0;
  int stub_lat = 4, stub_never = 0, stale_en = 0, clr_gen = 0;

  int cyc = 0, my_gen = 0;
  int acc_vld = 0, acc_cyc = 0, st_vld = 0, st_cyc = 0;
  int n_start = 0, n_done = 0, done_cyc = 0, rd_first = -1;
  logic done_err = 1'b0, real_d;
  int wa_q[$], rd_q[$];
  logic [31:0] wd_q[$];
  mat_acc_t prod;

  function automatic mat_acc_t matmul(mat_data_t a, mat_data_t b);
    mat_acc_t r;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        int s = 0;
        for (int k = 0; k < 8; k++) s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
        r[i][j] = 32'(s);
      end
    return r;
  endfunction

  // Array stub drives arr_done/arr_C at negedge; monitor samples 1ns later.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      arr_done = 1'b0; acc_vld = 0; st_vld = 0;
    end else begin
      real_d = (st_vld != 0) && (stub_never == 0) && (cyc >= st_cyc + stub_lat);
      if (real_d && !arr_done) arr_C = prod;
      arr_done = real_d || ((stale_en != 0) && (acc_vld != 0) &&
                            (cyc - acc_cyc >= 120) && (cyc - acc_cyc <= 134));
    end
    #1;
    if (clr_gen != my_gen) begin
      my_gen = clr_gen; rd_q.delete(); wa_q.delete(); wd_q.delete();
      n_start = 0; n_done = 0; rd_first = -1; done_err = 1'b0;
    end
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin acc_vld = 1; acc_cyc = cyc; st_vld = 0; end
      if (rd_en) begin if (rd_q.size() == 0) rd_first = cyc; rd_q.push_back(int'(rd_addr)); end
      if (wr_en) begin wa_q.push_back(int'(wr_addr)); wd_q.push_back(wr_data); end
      if (arr_start) begin
        n_start++; st_cyc = cyc; st_vld = 1; prod = matmul(arr_A, arr_B);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) arr_C[i][j] = $urandom;
      end
      if (job_done) begin n_done++; done_cyc = cyc; done_err = job_err; st_vld = 0; acc_vld = 0; end
    end
  end

  // Reference: C = A*B with A, B read row-major from memory, addresses mod 1024.
  function automatic int ref_elem(int a, int b, int k);
    int s = 0;
    for (int m = 0; m < 8; m++)
      s += mem_v[(a + (k / 8) * 8 + m) % 1024] * mem_v[(b + m * 8 + k % 8) % 1024];
    return s;
  endfunction

  function automatic int wr_bad(int a, int b, int c);
    int bad = 0;
    if (wa_q.size() != 64 || wd_q.size() != 64) return 999;
    for (int k = 0; k < 64; k++)
      if (wa_q[k] != (c + k) % 1024 || wd_q[k] !== 32'(ref_elem(a, b, k))) bad++;
    return bad;
  endfunction

  function automatic int rd_bad(int a, int b);
    int bad = 0;
    if (rd_q.size() != 128) return 999;
    for (int k = 0; k < 128; k++)
      if (rd_q[k] != ((k < 64) ? (a + k) % 1024 : (b + k - 64) % 1024)) bad++;
    return bad;
  endfunction

  function automatic int ab_bad(int a, int b);
    int bad = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        if (arr_A[i][j] !== 16'(mem_v[(a + i * 8 + j) % 1024])) bad++;
        if (arr_B[i][j] !== 16'(mem_v[(b + i * 8 + j) % 1024])) bad++;
      end
    return bad;
  endfunction

  task automatic tick(); @(posedge clk); #2; endtask

  task automatic fill_rand();
    for (int i = 0; i < 1024; i++) mem_v[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic start_job(int a, int b, int c);
    clr_gen++;
    cmd_a_base = AW'(a); cmd_b_base = AW'(b); cmd_c_base = AW'(c);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int i = 0;
    while (n_done == 0 && i < budget) begin tick(); i++; end
    tests++;
    if (n_done == 0) begin fails++; $display("FAIL job_done_wait: no job_done within %0d cycles", budget); end
    tick(); tick();
  endtask

  task automatic test_reset();
    cmd_valid = 1'b0; cmd_a_base = '0; cmd_b_base = '0; cmd_c_base = '0;
    rst_n = 1'b0;
    #23;
    tests++;
    if ({cmd_ready, busy, rd_en, wr_en, arr_start, job_done, job_err} !== 7'b1000000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 1000000", {cmd_ready, busy, rd_en, wr_en, arr_start, job_done, job_err});
    end
    tests++;
    if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0 || arr_A !== '0 || arr_B !== '0) begin
      fails++; $display("FAIL reset_data: rd_addr=%0d wr_addr=%0d wr_data=%0h, want all 0", rd_addr, wr_addr, wr_data);
    end
    tick(); rst_n = 1'b1; tick();
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_release: cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_identity();
    int bad = 0;
    for (int i = 0; i < 64; i++) begin mem_v[i] = i + 1; mem_v[64 + i] = (i / 8 == i % 8) ? 1 : 0; end
    stub_lat = 3;
    start_job(0, 64, 128);
    wait_done(600);
    for (int k = 0; k < 64; k++)
      if (k >= wd_q.size() || wd_q[k] !== 32'(k + 1) || wa_q[k] != 128 + k) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL identity_c: %0d bad words want 0", bad); end
    tests++;
    if (n_done != 1 || done_err !== 1'b0) begin fails++; $display("FAIL identity_done: pulses=%0d err=%b want 1 0", n_done, done_err); end
    tests++;
    if (n_start != 1 || st_cyc - acc_cyc != 130) begin
      fails++; $display("FAIL identity_start: starts=%0d offset=%0d want 1 130", n_start, st_cyc - acc_cyc);
    end
    tests++;
    if (done_cyc - st_cyc != 3 + 65) begin fails++; $display("FAIL identity_latency: got %0d want 68", done_cyc - st_cyc); end
    tests++;
    if (rd_bad(0, 64) != 0 || rd_first - acc_cyc != 1) begin
      fails++; $display("FAIL identity_reads: bad=%0d first_offset=%0d want 0 1", rd_bad(0, 64), rd_first - acc_cyc);
    end
  endtask

  task automatic test_diag();
    int col0 [8] = '{2, 8, 15, 7, 4, 17, 6, 7};
    int ccol0 [8] = '{10, 40, 75, 35, 20, 85, 30, 35};
    int bad = 0, lat;
    for (int i = 0; i < 64; i++) begin
      mem_v[200 + i] = (i / 8 == i % 8) ? 5 : 0;
      mem_v[300 + i] = (i % 8 == 0) ? col0[i / 8] : i;
    end
    lat = int'($urandom_range(1, 30)); stub_lat = lat;
    start_job(200, 300, 500);
    wait_done(600);
    for (int k = 0; k < 64; k++)
      if (k >= wd_q.size() || wd_q[k] !== 32'((k % 8 == 0) ? ccol0[k / 8] : 5 * k)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL diag_c: %0d bad words want 0", bad); end
    tests++;
    if (wr_bad(200, 300, 500) != 0) begin fails++; $display("FAIL diag_model: %0d bad want 0", wr_bad(200, 300, 500)); end
    tests++;
    if (done_cyc - st_cyc != lat + 65) begin fails++; $display("FAIL diag_latency: got %0d want %0d", done_cyc - st_cyc, lat + 65); end
  endtask

  task automatic test_addr_wrap();
    int b, c, bad = 0;
    fill_rand();
    b = int'($urandom_range(0, 1023)); c = int'($urandom_range(0, 1023));
    stub_lat = int'($urandom_range(1, 20));
    start_job(1000, b, c);
    wait_done(600);
    for (int k = 0; k < 64; k++)
      if (k >= rd_q.size() || rd_q[k] != ((k < 24) ? 1000 + k : k - 24)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL wrap_reads: %0d bad addresses want 0", bad); end
    tests++;
    if (rd_bad(1000, b) != 0) begin fails++; $display("FAIL wrap_readseq: %0d bad want 0", rd_bad(1000, b)); end
    tests++;
    if (wr_bad(1000, b, c) != 0) begin fails++; $display("FAIL wrap_model: %0d bad want 0", wr_bad(1000, b, c)); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int a, b, c, lat;
      fill_rand();
      a = int'($urandom_range(0, 1023)); b = int'($urandom_range(0, 1023)); c = int'($urandom_range(0, 1023));
      lat = int'($urandom_range(1, 40)); stub_lat = lat;
      start_job(a, b, c);
      // A second command while busy must be ignored.
      cmd_a_base = AW'($urandom); cmd_b_base = AW'($urandom); cmd_c_base = AW'($urandom);
      cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      cmd_valid = 1'b0;
      wait_done(600);
      tests++;
      if (wr_bad(a, b, c) != 0) begin fails++; $display("FAIL random_model[%0d]: %0d bad want 0", it, wr_bad(a, b, c)); end
      tests++;
      if (ab_bad(a, b) != 0) begin fails++; $display("FAIL random_operands[%0d]: %0d bad want 0", it, ab_bad(a, b)); end
      tests++;
      if (done_cyc - acc_cyc != 130 + lat + 65 || n_done != 1) begin
        fails++; $display("FAIL random_latency[%0d]: got %0d pulses=%0d want %0d 1", it, done_cyc - acc_cyc, n_done, 195 + lat);
      end
    end
  endtask

  task automatic test_timeout();
    fill_rand();
    stub_never = 1;
    start_job(10, 600, 900);
    wait_done(800);
    stub_never = 0;
    tests++;
    if (done_err !== 1'b1 || n_done != 1) begin fails++; $display("FAIL timeout_err: err=%b pulses=%0d want 1 1", done_err, n_done); end
    tests++;
    if (done_cyc - st_cyc != TO + 1) begin fails++; $display("FAIL timeout_latency: got %0d want %0d", done_cyc - st_cyc, TO + 1); end
    tests++;
    if (wa_q.size() != 0) begin fails++; $display("FAIL timeout_writes: got %0d want 0", wa_q.size()); end
    tick();
    tests++;
    if (job_err !== 1'b1) begin fails++; $display("FAIL timeout_sticky: job_err=%b want 1", job_err); end
  endtask

  task automatic test_stale();
    int lat;
    fill_rand();
    lat = int'($urandom_range(1, 10)); stub_lat = lat; stale_en = 1;
    start_job(40, 700, 300);
    tick();
    tests++;
    if (job_err !== 1'b0) begin fails++; $display("FAIL stale_errclear: job_err=%b want 0", job_err); end
    wait_done(600);
    stale_en = 0;
    tests++;
    if (n_start != 1 || st_cyc - acc_cyc != 135) begin
      fails++; $display("FAIL stale_start: starts=%0d offset=%0d want 1 135", n_start, st_cyc - acc_cyc);
    end
    tests++;
    if (wr_bad(40, 700, 300) != 0 || done_err !== 1'b0) begin
      fails++; $display("FAIL stale_model: bad=%0d err=%b want 0 0", wr_bad(40, 700, 300), done_err);
    end
  endtask

  task automatic test_mid_reset();
    int i = 0;
    fill_rand();
    stub_lat = 5;
    start_job(100, 400, 800);
    while (wa_q.size() < 20 && i < 600) begin tick(); i++; end
    tests++;
    if (wa_q.size() != 20 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL midreset_reach: writes=%0d ready=%b busy=%b want 20 0 1", wa_q.size(), cmd_ready, busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cmd_ready, busy, rd_en, wr_en, arr_start, job_done, job_err} !== 7'b1000000 || wr_addr !== '0) begin
      fails++; $display("FAIL midreset_outputs: got %b wr_addr=%0d want 1000000 0",
                        {cmd_ready, busy, rd_en, wr_en, arr_start, job_done, job_err}, wr_addr);
    end
    tests++;
    if (arr_A !== '0 || arr_B !== '0) begin fails++; $display("FAIL midreset_matrices: not cleared, want 0"); end
    tick(); tick(); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    tests++;
    if (wa_q.size() != 20 || n_done != 0) begin
      fails++; $display("FAIL midreset_abandon: writes=%0d pulses=%0d want 20 0", wa_q.size(), n_done);
    end
  endtask

  task automatic test_back_to_back();
    int a, b, c;
    for (int it = 0; it < 2; it++) begin
      fill_rand();
      a = int'($urandom_range(0, 1023)); b = int'($urandom_range(0, 1023)); c = int'($urandom_range(0, 1023));
      stub_lat = int'($urandom_range(1, 15));
      start_job(a, b, c);
      wait_done(600);
      tests++;
      if (wr_bad(a, b, c) != 0 || done_err !== 1'b0 || n_done != 1) begin
        fails++; $display("FAIL b2b[%0d]: bad=%0d err=%b pulses=%0d want 0 0 1", it, wr_bad(a, b, c), done_err, n_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_diag();
    test_addr_wrap();
    test_random();
    test_timeout();
    test_stale();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
